// File: rtl/hazard_pkg.sv
// Shared constants and forward-select encoding for the hazard scoreboard.
// 0 = register file, 2p+2 = M-stage write port p, 2p+1 = W-stage write port p.
package hazard_pkg;

  localparam int REG_PC  = 15;
  localparam int FSEL_RF = 0;

  function automatic int fsel_m(input int p);
    return 2 * p + 2;
  endfunction

  function automatic int fsel_w(input int p);
    return 2 * p + 1;
  endfunction

  function automatic bit fsel_is_m(input int sel);
    return (sel != FSEL_RF) && ((sel % 2) == 0);
  endfunction

  function automatic int fsel_port(input int sel);
    return (sel - 1) / 2;
  endfunction

  // Select field must hold the register-file code plus one code per M and W port.
  function automatic bit fsw_ok(input int nwp, input int fsw);
    return (fsw >= $clog2(2 * nwp + 1));
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_prio_mux.sv
// Single-source forward matcher over the M and W write ports; purely combinational.
// M ports beat W ports, lower port index beats higher; the PC register never matches.
module fwd_prio_mux
  import hazard_pkg::*;
#(
  parameter int NWP = 2,
  parameter int RW  = 4,
  parameter int FSW = 3
) (
  input  logic [RW-1:0]     src_i,
  input  logic              src_vld_i,
  input  logic [NWP*RW-1:0] dst_m_i,
  input  logic [NWP-1:0]    we_m_i,
  input  logic [NWP*RW-1:0] dst_w_i,
  input  logic [NWP-1:0]    we_w_i,
  output logic [FSW-1:0]    sel_o
);

  logic src_ok;
  logic hit;

  assign src_ok = src_vld_i && (src_i != RW'(REG_PC));

  always_comb begin
    sel_o = '0;
    hit   = 1'b0;
    for (int p = 0; p < NWP; p++) begin
      if (!hit && src_ok && we_m_i[p] && (dst_m_i[p*RW +: RW] == src_i)) begin
        sel_o = FSW'(fsel_m(p));
        hit   = 1'b1;
      end
    end
    for (int p = 0; p < NWP; p++) begin
      if (!hit && src_ok && we_w_i[p] && (dst_w_i[p*RW +: RW] == src_i)) begin
        sel_o = FSW'(fsel_w(p));
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the F/D/E/M/W core: tracks E/M/W destination tags, drives forward selects,
// load-use and multicycle stalls and branch flushes, all combinational from registered state.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int NWP  = 2,
  parameter int RW   = 4,
  parameter int LATW = 3,
  parameter int FSW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*RW-1:0]   src_d,
  input  logic [NSRC-1:0]      src_vld_d,
  input  logic [NWP*RW-1:0]    dst_d,
  input  logic [NWP-1:0]       dst_we_d,
  input  logic                 load_d,
  input  logic [LATW-1:0]      mc_lat_d,
  input  logic                 cond_pass_e,
  input  logic                 branch_taken_e,
  output logic [NSRC*FSW-1:0]  fwd_sel_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 mc_busy
);

  if (!fsw_ok(NWP, FSW)) begin : g_bad_fsw
    $error("hazard_scoreboard: FSW too narrow for 2*NWP+1 forward-select codes");
  end

  logic [NWP*RW-1:0]  dst_e_q, dst_m_q, dst_w_q;
  logic [NWP-1:0]     we_e_q, we_m_q, we_w_q;
  logic               load_e_q;
  logic [NSRC*RW-1:0] src_e_q;
  logic [NSRC-1:0]    vld_e_q;
  logic [LATW-1:0]    mc_cnt_q, mc_cnt_d;

  logic lu_match;
  logic lu_hit;
  logic br_hit;

  assign mc_busy = (mc_cnt_q != '0);

  always_comb begin
    lu_match = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_vld_d[k] && (src_d[k*RW +: RW] == dst_e_q[RW-1:0])) begin
        lu_match = 1'b1;
      end
    end
  end

  // A multicycle op owns E, so branches and load-use are both masked while busy;
  // a taken branch overrides load-use since the D instruction is being killed anyway.
  assign br_hit = branch_taken_e & ~mc_busy;
  assign lu_hit = lu_match & load_e_q & we_e_q[0] & ~mc_busy & ~br_hit;

  assign stall_f = lu_hit | mc_busy;
  assign stall_d = lu_hit | mc_busy;
  assign stall_e = mc_busy;
  assign flush_d = br_hit;
  assign flush_e = br_hit | lu_hit;

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (mc_busy) begin
      mc_cnt_d = mc_cnt_q - LATW'(1);
    end else if (!flush_e) begin
      mc_cnt_d = mc_lat_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst_e_q  <= '0;
      we_e_q   <= '0;
      load_e_q <= 1'b0;
      src_e_q  <= '0;
      vld_e_q  <= '0;
      dst_m_q  <= '0;
      we_m_q   <= '0;
      dst_w_q  <= '0;
      we_w_q   <= '0;
      mc_cnt_q <= '0;
    end else begin
      dst_w_q  <= dst_m_q;
      we_w_q   <= we_m_q;
      mc_cnt_q <= mc_cnt_d;
      if (mc_busy) begin
        we_m_q <= '0;
      end else begin
        dst_m_q <= dst_e_q;
        we_m_q  <= we_e_q & {NWP{cond_pass_e}};
        if (flush_e) begin
          we_e_q   <= '0;
          vld_e_q  <= '0;
          load_e_q <= 1'b0;
        end else begin
          dst_e_q  <= dst_d;
          we_e_q   <= dst_we_d;
          load_e_q <= load_d;
          src_e_q  <= src_d;
          vld_e_q  <= src_vld_d;
        end
      end
    end
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_prio_mux #(
      .NWP (NWP),
      .RW  (RW),
      .FSW (FSW)
    ) u_fwd_prio_mux (
      .src_i     (src_e_q[k*RW +: RW]),
      .src_vld_i (vld_e_q[k]),
      .dst_m_i   (dst_m_q),
      .we_m_i    (we_m_q),
      .dst_w_i   (dst_w_q),
      .we_w_i    (we_w_q),
      .sel_o     (fwd_sel_e[k*FSW +: FSW])
    );
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

  localparam int NSRC = 4;
  localparam int NWP  = 2;
  localparam int RW   = 4;
  localparam int LATW = 3;
  localparam int FSW  = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NSRC*RW-1:0]  src_d;
  logic [NSRC-1:0]     src_vld_d;
  logic [NWP*RW-1:0]   dst_d;
  logic [NWP-1:0]      dst_we_d;
  logic                load_d;
  logic [LATW-1:0]     mc_lat_d;
  logic                cond_pass_e;
  logic                branch_taken_e;
  logic [NSRC*FSW-1:0] fwd_sel_e;
  logic                stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NSRC(NSRC), .NWP(NWP), .RW(RW), .LATW(LATW), .FSW(FSW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .src_d          (src_d),
    .src_vld_d      (src_vld_d),
    .dst_d          (dst_d),
    .dst_we_d       (dst_we_d),
    .load_d         (load_d),
    .mc_lat_d       (mc_lat_d),
    .cond_pass_e    (cond_pass_e),
    .branch_taken_e (branch_taken_e),
    .fwd_sel_e      (fwd_sel_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .mc_busy        (mc_busy)
  );

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic [NWP-1:0][RW-1:0]  dst;
    logic [NWP-1:0]          we;
    logic                    load;
    logic [NSRC-1:0][RW-1:0] src;
    logic [NSRC-1:0]         sv;
  } ins_t;

  typedef struct {
    logic [NSRC*FSW-1:0] fwd;
    logic [5:0]          fl;
    string               tag;
  } exp_t;

  ins_t e_i, m_i, w_i;
  int   busy_left;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [5:0] act_fl;

  function automatic ins_t d_ins();
    ins_t x;
    x.dst  = dst_d;
    x.we   = dst_we_d;
    x.load = load_d;
    x.src  = src_d;
    x.sv   = src_vld_d;
    return x;
  endfunction

  task automatic model_reset();
    e_i = '0; m_i = '0; w_i = '0; busy_left = 0;
  endtask

  // Flags order: {mc_busy, stall_f, stall_d, stall_e, flush_d, flush_e}
  function automatic void model_eval(output logic [NSRC*FSW-1:0] fwd, output logic [5:0] fl,
                                     output logic br, output logic lu);
    int sel;
    bit busy, hazard;
    busy = (busy_left > 0);
    fwd = '0;
    for (int k = 0; k < NSRC; k++) begin
      sel = 0;
      if (e_i.sv[k] && e_i.src[k] != RW'(15)) begin
        // Walk from lowest to highest priority; the last hit is the winner.
        for (int p = NWP-1; p >= 0; p--)
          if (w_i.we[p] && w_i.dst[p] == e_i.src[k]) sel = 2*p + 1;
        for (int p = NWP-1; p >= 0; p--)
          if (m_i.we[p] && m_i.dst[p] == e_i.src[k]) sel = 2*p + 2;
      end
      fwd[k*FSW +: FSW] = FSW'(sel);
    end
    hazard = 0;
    for (int k = 0; k < NSRC; k++)
      if (src_vld_d[k] && src_d[k*RW +: RW] == e_i.dst[0]) hazard = 1;
    br = branch_taken_e && !busy;
    lu = !busy && !br && e_i.load && e_i.we[0] && hazard;
    fl = {busy, lu || busy, lu || busy, busy, br, br || lu};
  endfunction

  task automatic model_advance(input logic br, input logic lu);
    w_i = m_i;
    if (busy_left > 0) begin
      m_i = '0;
      busy_left--;
    end else begin
      m_i = e_i;
      m_i.we = e_i.we & {NWP{cond_pass_e}};
      if (br || lu) begin
        e_i = '0;
        busy_left = 0;
      end else begin
        e_i = d_ins();
        busy_left = int'(mc_lat_d);
      end
    end
  endtask

  task automatic step(input string tag);
    exp_t x;
    logic br, lu;
    model_eval(x.fwd, x.fl, br, lu);
    x.tag = tag;
    exp_q.push_back(x);
    @(posedge clk);
    if (reset) model_advance(br, lu);
    #1;
  endtask

  task automatic set_d(input logic [NSRC*RW-1:0] s, input logic [NSRC-1:0] sv,
                       input logic [NWP*RW-1:0] d, input logic [NWP-1:0] we,
                       input logic ld, input logic [LATW-1:0] lat);
    src_d = s; src_vld_d = sv; dst_d = d; dst_we_d = we; load_d = ld; mc_lat_d = lat;
  endtask

  task automatic nop();
    set_d('0, '0, '0, '0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      vectors++;
      act_fl = {mc_busy, stall_f, stall_d, stall_e, flush_d, flush_e};
      if (fwd_sel_e !== x.fwd || act_fl !== x.fl) begin
        miscompares++;
        $display("FAIL %s: got fwd_sel_e=%h flags(busy,sf,sd,se,fd,fe)=%b, expected fwd_sel_e=%h flags=%b",
                 x.tag, fwd_sel_e, act_fl, x.fwd, x.fl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    nop();
    cond_pass_e = 1'b1;
    branch_taken_e = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step("reset_state");
    step("reset_state2");
    reset = 1'b1;

    // M beats W: ADD r3, SUB r3, two readers of r3 on src0
    set_d({4'd0, 4'd0, 4'd2, 4'd1}, 4'b0011, {4'd0, 4'd3}, 2'b01, 1'b0, '0); step("add_r3");
    set_d({4'd0, 4'd0, 4'd5, 4'd4}, 4'b0011, {4'd0, 4'd3}, 2'b01, 1'b0, '0); step("sub_r3");
    set_d({4'd0, 4'd0, 4'd0, 4'd3}, 4'b0001, '0, '0, 1'b0, '0);             step("rd_r3_a");
    step("rd_r3_b");
    nop(); step("fwd_m_over_w");
    step("fwd_w_after_m_empty");
    step("drain_a");

    // Port-1 forwarding: r4 on port0, r5 on port1, reader of r5 on src2
    set_d({4'd0, 4'd0, 4'd2, 4'd1}, 4'b0011, {4'd5, 4'd4}, 2'b11, 1'b0, '0); step("mul_r4_r5");
    set_d({4'd0, 4'd5, 4'd0, 4'd0}, 4'b0100, '0, '0, 1'b0, '0);             step("rd_r5");
    nop(); step("fwd_m_port1");
    step("drain_b");

    // Load-use: LDR r2 then ADD reading r2 on src1
    set_d({4'd0, 4'd0, 4'd0, 4'd1}, 4'b0001, {4'd0, 4'd2}, 2'b01, 1'b1, '0); step("ldr_r2");
    set_d({4'd0, 4'd0, 4'd2, 4'd0}, 4'b0010, {4'd0, 4'd6}, 2'b01, 1'b0, '0); step("load_use_stall");
    step("load_use_release");
    nop(); step("load_use_fwd_w");
    step("drain_c");

    // Multicycle op with 3 extra cycles writing r6; reader of r6 waits in D
    set_d({4'd0, 4'd0, 4'd2, 4'd1}, 4'b0011, {4'd0, 4'd6}, 2'b01, 1'b0, 3'd3); step("mc_issue");
    set_d({4'd0, 4'd0, 4'd0, 4'd6}, 4'b0001, '0, '0, 1'b0, '0); step("mc_busy3");
    step("mc_busy2");
    step("mc_busy1");
    step("mc_leave");
    nop(); step("mc_fwd_m");
    step("drain_d");

    // Branch and load-use in the same cycle, then branch during a multicycle op
    set_d({4'd0, 4'd0, 4'd0, 4'd1}, 4'b0001, {4'd0, 4'd2}, 2'b01, 1'b1, '0); step("ldr_r2_b");
    set_d({4'd0, 4'd0, 4'd2, 4'd0}, 4'b0010, {4'd0, 4'd6}, 2'b01, 1'b0, '0);
    branch_taken_e = 1'b1; step("branch_beats_load_use");
    branch_taken_e = 1'b0; nop(); step("after_branch");
    set_d({4'd0, 4'd0, 4'd2, 4'd1}, 4'b0011, {4'd0, 4'd7}, 2'b01, 1'b0, 3'd2); step("mc2_issue");
    nop(); branch_taken_e = 1'b1; step("branch_in_busy");
    step("branch_in_busy2");
    step("branch_after_busy");
    branch_taken_e = 1'b0; step("drain_e");

    // Condition-failed writer never forwards
    set_d({4'd0, 4'd0, 4'd2, 4'd1}, 4'b0011, {4'd0, 4'd7}, 2'b01, 1'b0, '0); step("add_r7");
    set_d({4'd7, 4'd0, 4'd0, 4'd0}, 4'b1000, '0, '0, 1'b0, '0);
    cond_pass_e = 1'b0; step("cond_fail");
    cond_pass_e = 1'b1; nop(); step("cond_fail_no_fwd");
    step("drain_f");

    // Async reset in the middle of a multicycle op
    set_d({4'd0, 4'd0, 4'd2, 4'd1}, 4'b0011, {4'd0, 4'd6}, 2'b01, 1'b0, 3'd3); step("mc_rst_issue");
    nop(); step("mc_rst_cnt3");
    reset = 1'b0; model_reset(); step("async_reset_mid_mc");
    step("reset_hold");
    reset = 1'b1;
    set_d({4'd0, 4'd0, 4'd0, 4'd6}, 4'b0001, '0, '0, 1'b0, '0); step("post_reset_rd");
    nop(); step("post_reset_fwd_rf");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [NSRC*RW-1:0] s;
      logic [NWP*RW-1:0]  d;
      for (int k = 0; k < NSRC; k++)
        s[k*RW +: RW] = ($urandom_range(0, 9) == 0) ? RW'(15) : RW'($urandom_range(0, 7));
      for (int p = 0; p < NWP; p++)
        d[p*RW +: RW] = ($urandom_range(0, 9) == 0) ? RW'(15) : RW'($urandom_range(0, 7));
      set_d(s, NSRC'($urandom_range(0, 15)), d, NWP'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0) ? LATW'($urandom_range(1, 7)) : '0);
      cond_pass_e    = ($urandom_range(0, 3) != 0);
      branch_taken_e = ($urandom_range(0, 7) == 0);
      step("random");
    end

    nop();
    cond_pass_e = 1'b1;
    branch_taken_e = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
